// File: rtl/piso_serializer.sv
// piso_serializer: loads a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per cycle
// as an enable-qualified serial stream, with downstream hold and bubble-free back-to-back words.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             out_sd,
  output logic             out_en,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_last, w_xfer;
  assign busy      = r_state == SHIFT;
  assign w_last    = busy && r_cnt == LAST;
  assign in_ready  = r_state == IDLE || (w_last && !hold);
  assign w_xfer    = in_valid && in_ready;
  assign out_en    = busy && !hold;
  assign out_last  = w_last;
  assign out_sd    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  // A transfer takes priority, so the last bit of a word and the reload share one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_xfer) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = in_data;
      w_cnt_nxt   = '0;
    end else if (out_en) begin
      w_shift_nxt = w_shifted;
      w_cnt_nxt   = w_last ? '0 : r_cnt + CW'(1);
      w_state_nxt = w_last ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
endmodule
